// File: rtl/ofs_plat_prim_burstcount0_tracking_gearbox.sv
// Splits 0-origin source bursts into sink-sized pieces, honouring page and natural-alignment
// limits together, and tags each piece with SOP/EOP and a split index for response merging.
module ofs_plat_prim_burstcount0_tracking_gearbox #(
    parameter int ADDR_WIDTH         = 42,
    parameter int SOURCE_BURST_WIDTH = 8,
    parameter int SINK_BURST_WIDTH   = 3,
    parameter int NATURAL_ALIGNMENT  = 0,
    parameter int PAGE_SIZE          = 64,
    parameter int USER_WIDTH         = 8
) (
    input  logic                          clk,
    input  logic                          reset,

    input  logic                          m_valid,
    output logic                          m_ready,
    input  logic [ADDR_WIDTH-1:0]         m_addr,
    input  logic [SOURCE_BURST_WIDTH-1:0] m_burstcount,
    input  logic [USER_WIDTH-1:0]         m_user,

    output logic                          s_valid,
    input  logic                          s_ready,
    output logic [ADDR_WIDTH-1:0]         s_addr,
    output logic [SINK_BURST_WIDTH-1:0]   s_burstcount,
    output logic [USER_WIDTH-1:0]         s_user,
    output logic                          s_sop,
    output logic                          s_eop,
    output logic [SOURCE_BURST_WIDTH:0]   s_split_idx
);

    localparam int RW       = SOURCE_BURST_WIDTH + 1;
    localparam int SW       = SINK_BURST_WIDTH;
    localparam int SINK_MAX = 2 ** SW;

    typedef enum logic {StIdle, StActive} state_t;

    state_t                  state_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [RW-1:0]           rem_beats_q;
    logic [USER_WIDTH-1:0]   user_q;
    logic [RW-1:0]           split_idx_q;

    // All lengths are 1-origin and never exceed SINK_MAX.
    logic [SW:0] cap_len, page_len, nat_len, piece_len;

    always_comb begin
        cap_len = (rem_beats_q >= RW'(SINK_MAX)) ? (SW+1)'(SINK_MAX) : rem_beats_q[SW:0];
    end

    if (PAGE_SIZE != 0) begin : g_page
        localparam int PB = $clog2(PAGE_SIZE);
        logic [PB:0] room;
        always_comb begin
            room     = (PB+1)'(PAGE_SIZE) - {1'b0, cur_addr_q[PB-1:0]};
            page_len = (room >= (PB+1)'(SINK_MAX)) ? (SW+1)'(SINK_MAX) : room[SW:0];
        end
    end else begin : g_no_page
        assign page_len = (SW+1)'(SINK_MAX);
    end

    if (NATURAL_ALIGNMENT != 0) begin : g_nat
        // Walk powers of two upward while the address stays aligned and the piece still fits.
        always_comb begin
            logic aligned;
            aligned = 1'b1;
            nat_len = (SW+1)'(1);
            for (int k = 0; k <= SW; k++) begin
                if (aligned && ((((SW+1)'(1)) << k) <= cap_len)) begin
                    nat_len = ((SW+1)'(1)) << k;
                end
                if (k < SW) begin
                    aligned = aligned & ~cur_addr_q[k];
                end
            end
        end
    end else begin : g_no_nat
        assign nat_len = (SW+1)'(SINK_MAX);
    end

    always_comb begin
        piece_len = cap_len;
        if (page_len < piece_len) piece_len = page_len;
        if (nat_len < piece_len) piece_len = nat_len;
    end

    assign s_valid      = (state_q == StActive);
    assign s_addr       = cur_addr_q;
    assign s_burstcount = SW'(piece_len - (SW+1)'(1));
    assign s_user       = user_q;
    assign s_sop        = (split_idx_q == '0);
    assign s_eop        = (RW'(piece_len) == rem_beats_q);
    assign s_split_idx  = split_idx_q;

    // Accepting alongside the final handshake keeps back-to-back requests bubble-free.
    assign m_ready = !reset && ((state_q == StIdle) || (s_valid && s_ready && s_eop));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            cur_addr_q  <= '0;
            rem_beats_q <= '0;
            user_q      <= '0;
            split_idx_q <= '0;
        end else if (m_valid && m_ready) begin
            state_q     <= StActive;
            cur_addr_q  <= m_addr;
            rem_beats_q <= RW'(m_burstcount) + RW'(1);
            user_q      <= m_user;
            split_idx_q <= '0;
        end else if (s_valid && s_ready) begin
            cur_addr_q  <= cur_addr_q + ADDR_WIDTH'(piece_len);
            rem_beats_q <= rem_beats_q - RW'(piece_len);
            split_idx_q <= split_idx_q + RW'(1);
            if (s_eop) state_q <= StIdle;
        end
    end

endmodule

// File: doc/ofs_plat_prim_burstcount0_tracking_gearbox.md
Name: ofs_plat_prim_burstcount0_tracking_gearbox

Overview:
Splits each source burst request into one or more sink burst requests. Burst counts use 0-origin (AXI) encoding on both sides. Natural alignment and page-boundary limits are applied together, not as exclusive modes. Uses valid/ready handshakes on both sides and carries a user tag through. Tags every sink piece with SOP/EOP flags and a split index so downstream response-merge logic can reassemble the original burst.

Parameters:
ADDR_WIDTH, 42, address width in bus-width units (one unit = one beat).
SOURCE_BURST_WIDTH, 8, m_burstcount width; max source burst is 2**SOURCE_BURST_WIDTH beats.
SINK_BURST_WIDTH, 3, s_burstcount width; SINK_MAX = 2**SINK_BURST_WIDTH beats; must be <= SOURCE_BURST_WIDTH.
NATURAL_ALIGNMENT, 0, non-zero: every sink burst is a power-of-2 length, with its address aligned to that length.
PAGE_SIZE, 64, page size in beats (power of 2, 0 = no limit); no sink burst crosses a page; must be >= SINK_MAX when non-zero.
USER_WIDTH, 8, width of the pass-through tag.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
m_valid  input  1  source request valid
m_ready  output  1  source request accepted when m_valid && m_ready
m_addr  input  ADDR_WIDTH  source start address
m_burstcount  input  SOURCE_BURST_WIDTH  source beats minus 1
m_user  input  USER_WIDTH  tag
s_valid  output  1  sink piece valid
s_ready  input  1  sink accepts piece
s_addr  output  ADDR_WIDTH  piece start address
s_burstcount  output  SINK_BURST_WIDTH  piece beats minus 1
s_user  output  USER_WIDTH  copy of m_user for every piece
s_sop  output  1  first piece of a source request
s_eop  output  1  last piece of a source request
s_split_idx  output  SOURCE_BURST_WIDTH+1  piece index within the source request, starting at 0

Behaviour:
- Clock and reset: one clock `clk`; reset is synchronous and active-high, port `reset`.
- State: IDLE / ACTIVE. Registers: cur_addr, rem_beats (SOURCE_BURST_WIDTH+1 bits, 1-origin), user, split_idx.
- Reset: state=IDLE, s_valid=0, m_ready=0 while reset is high; rem_beats=0, split_idx=0.
  - Reset mid-operation drops any pending piece without emitting it.
- m_ready = !reset && (IDLE || (s_valid && s_ready && s_eop)).
  - This allows back-to-back requests with no bubble.
- Accept in cycle N latches cur_addr=m_addr, rem_beats=m_burstcount+1, split_idx=0; state becomes ACTIVE.
  - The first piece is visible at N+1, so latency is one cycle.
- s_valid = (state==ACTIVE). s_* outputs are combinational from the registers and hold stable while s_valid && !s_ready.
- Piece length L (1-origin) = min(rem_beats, SINK_MAX, page_room, nat_len).
  - page_room = PAGE_SIZE - (cur_addr mod PAGE_SIZE), or unlimited when PAGE_SIZE=0.
  - nat_len = largest power of 2 that is <= min(rem_beats, SINK_MAX) and divides cur_addr; cur_addr=0 counts as aligned to anything. Unlimited when NATURAL_ALIGNMENT=0.
- Piece outputs: s_burstcount = L-1; s_sop = (split_idx==0); s_eop = (L==rem_beats).
- On s_valid && s_ready:
  - cur_addr += L, modulo 2**ADDR_WIDTH; wrap is silent.
  - rem_beats -= L; split_idx += 1.
  - If s_eop: state=IDLE, unless a new request is accepted in the same cycle, in which case the registers reload and state stays ACTIVE.
- A 1-beat source request yields one piece with s_sop=s_eop=1.
- No combinational path from m_valid to s_valid. m_ready depends combinationally on s_ready.

Test Plan:
1. NAT=0, PAGE=0, m_addr=0x10, m_burstcount=19 -> pieces (0x10,bc7,idx0,sop), (0x18,bc7,idx1), (0x20,bc3,idx2,eop); m_ready low until the eop handshake.
2. PAGE=64, NAT=0, m_addr=0x3C, m_burstcount=9 -> (0x3C,bc3,sop), (0x40,bc5,eop).
3. NAT=1, PAGE=64, m_addr=0x3, m_burstcount=12 -> (0x3,bc0), (0x4,bc3), (0x8,bc7,eop); total 13 beats, each piece naturally aligned.
4. Backpressure: s_ready=0 for 3 cycles on piece idx1 of scenario 1 -> s_addr=0x18, s_burstcount=7, s_split_idx=1 held stable; m_ready=0 throughout.
5. Back-to-back: request A (0x100,bc7), then request B (0x200,bc0) offered while A's eop is accepted -> s_valid stays high; B emits at the next cycle with sop=eop=1 and s_user=B's tag.
6. Reset asserted while ACTIVE with rem_beats=12 -> next cycle s_valid=0; after deassert m_ready=1; a new request (0x0,bc0) emits exactly one piece with split_idx=0.
